lpc_filter: RTL

- Sits between the LPC decoder and lpc2mem in the lpc_clock domain.
- Receives each decoded cycle (type/dir, address, data, one-cycle strobe).
- Forwards only cycles that match a per-type enable mask and, optionally, an address window; drops the rest.
- Keeps saturating pass/drop counters so the host can tell filtered traffic from ring-buffer overflow.

---
 rtl/lpc_filter_pkg.sv | 37 +++
 rtl/lpc_filter_sat_counter.sv | 31 +++
 rtl/lpc_filter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lpc_filter_pkg.sv
// lpc_filter_pkg
//   Shared definitions for the LPC cycle filter: record field widths, the
//   decoder's cycle type/direction codes, the power-on type mask and the
//   inclusive address-window helper.
//   Optional feature macro used by the filter: LPC_FILTER_DEDUP_EN.
package lpc_filter_pkg;

  localparam int CYC_W  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;

  // Code layout follows the LPC START/CYCTYPE nibble: [3:2] space, [1] dir.
  localparam logic [CYC_W-1:0] CYC_IO_RD  = 4'h0;
  localparam logic [CYC_W-1:0] CYC_IO_WR  = 4'h2;
  localparam logic [CYC_W-1:0] CYC_MEM_RD = 4'h4;
  localparam logic [CYC_W-1:0] CYC_MEM_WR = 4'h6;
  localparam logic [CYC_W-1:0] CYC_DMA_RD = 4'h8;
  localparam logic [CYC_W-1:0] CYC_DMA_WR = 4'hA;
  localparam logic [CYC_W-1:0] CYC_FW     = 4'hC;

  // IO writes only: enough to sniff POST codes on port 0x80.
  localparam logic [15:0] TYPE_MASK_DEFAULT = 16'h0001 << CYC_IO_WR;

  typedef struct packed {
    logic [CYC_W-1:0]  cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } lpc_rec_t;

  // Inclusive, unsigned; lo > hi yields an empty window.
  function automatic logic addr_in_window(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] lo,
                                          input logic [ADDR_W-1:0] hi);
    return (lo <= addr) && (addr <= hi);
  endfunction

endpackage

// File: rtl/lpc_filter_sat_counter.sv
// lpc_filter_sat_counter
//   Event counter that sticks at its all-ones value instead of wrapping.
//   Ports:
//     clock    - rising-edge clock
//     reset    - asynchronous, active-high clear
//     i_inc    - count one event this cycle
//     o_count  - current count (CNT_W bits)
module lpc_filter_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/lpc_filter.sv
// lpc_filter
//   Two-stage filter between the LPC decoder and lpc2mem (lpc_clock domain).
//   Stage 1 registers each strobed record together with its type-mask and
//   address-window verdicts; stage 2 forwards or drops it and bumps the
//   matching saturating counter. Strobe at cycle N -> out_clock_enable at N+2.
//   Optional: define LPC_FILTER_DEDUP_EN to drop a record identical to the
//   last forwarded one while the DEDUP_HOLD holdoff is still running.
//   Ports:
//     clock, reset            - lpc_clock, async active-high reset
//     in_cyctype_dir/addr/data- decoded record, valid on in_clock_enable
//     type_mask               - bit k passes records of type code k
//     window_en, addr_low/high- optional inclusive address window
//     out_cyctype_dir/addr/data, out_clock_enable - forwarded record + strobe
//     pass_count, drop_count  - saturating forwarded/rejected counters
module lpc_filter
  import lpc_filter_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int DEDUP_HOLD = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CYC_W-1:0]  in_cyctype_dir,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_clock_enable,
  input  logic [15:0]       type_mask,
  input  logic              window_en,
  input  logic [ADDR_W-1:0] addr_low,
  input  logic [ADDR_W-1:0] addr_high,
  output logic [CYC_W-1:0]  out_cyctype_dir,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_clock_enable,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  drop_count
);

  // Stage 1
  logic     r_s1_valid;
  lpc_rec_t r_s1_rec;
  logic     r_s1_type_ok;
  logic     r_s1_win_ok;

  // Stage 2 / outputs
  lpc_rec_t r_out_rec;
  logic     r_out_ce;

  logic w_keep;
  logic w_dup;
  logic w_pass_inc;
  logic w_drop_inc;

  // Config is sampled with the strobe so later config edits cannot
  // retroactively change the verdict of a record already in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_rec     <= '0;
      r_s1_type_ok <= 1'b0;
      r_s1_win_ok  <= 1'b0;
    end else begin
      r_s1_valid <= in_clock_enable;
      if (in_clock_enable) begin
        r_s1_rec.cyc  <= in_cyctype_dir;
        r_s1_rec.addr <= in_addr;
        r_s1_rec.data <= in_data;
        r_s1_type_ok  <= type_mask[in_cyctype_dir];
        r_s1_win_ok   <= !window_en || addr_in_window(in_addr, addr_low, addr_high);
      end
    end
  end

`ifdef LPC_FILTER_DEDUP_EN
  localparam int HOLD_W = $clog2(DEDUP_HOLD) + 1;

  logic              r_dd_valid;
  lpc_rec_t          r_dd_rec;
  logic [HOLD_W-1:0] r_dd_hold;

  // Compared against the state before this cycle's update, so the second of
  // two back-to-back identical records sees the first one as stored.
  assign w_dup = r_dd_valid && (r_dd_rec == r_s1_rec) && (r_dd_hold != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dd_valid <= 1'b0;
      r_dd_rec   <= '0;
      r_dd_hold  <= '0;
    end else if (w_keep) begin
      r_dd_valid <= 1'b1;
      r_dd_rec   <= r_s1_rec;
      r_dd_hold  <= HOLD_W'(DEDUP_HOLD);
    end else if (r_dd_hold != '0) begin
      r_dd_hold <= r_dd_hold - HOLD_W'(1);
    end else begin
      r_dd_valid <= 1'b0;
    end
  end
`else
  localparam int unused_dedup_hold = DEDUP_HOLD;

  assign w_dup = 1'b0;
`endif

  assign w_keep     = r_s1_valid && r_s1_type_ok && r_s1_win_ok && !w_dup;
  assign w_pass_inc = w_keep;
  assign w_drop_inc = r_s1_valid && !w_keep;

  // out_* fields only load on a forwarded record and hold otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_rec <= '0;
      r_out_ce  <= 1'b0;
    end else begin
      r_out_ce <= w_keep;
      if (w_keep) begin
        r_out_rec <= r_s1_rec;
      end
    end
  end

  lpc_filter_sat_counter #(
    .CNT_W (CNT_W)
  ) u_pass_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_pass_inc),
    .o_count (pass_count)
  );

  lpc_filter_sat_counter #(
    .CNT_W (CNT_W)
  ) u_drop_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_drop_inc),
    .o_count (drop_count)
  );

  assign out_cyctype_dir  = r_out_rec.cyc;
  assign out_addr         = r_out_rec.addr;
  assign out_data         = r_out_rec.data;
  assign out_clock_enable = r_out_ce;

endmodule
